// File: rtl/cpu1_oci_dct_capture.sv
// Debug-capture-trace buffer: captures DCT words between arm and test_ending,
// then drains through a registered pop port until the buffer is empty.
module cpu1_oci_dct_capture #(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              dct_valid,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic              test_ending,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  dct_count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              test_has_ended,
    output logic [1:0]        state_dbg
);

    // Handshake: a pop is accepted on a rising edge where rd_en=1 and empty=0;
    // rd_valid pulses for exactly one cycle after that edge with the popped word
    // on rd_data, which otherwise holds its last value. dct_valid has no
    // backpressure: words offered while full are dropped or overwrite the oldest.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_ENDED   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              capture_en;
    logic              rearm;
    logic              pop_acc;
    logic              wr_req;
    logic              wr_store;
    logic              wr_wrap;
    logic              wr_drop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arm) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (test_ending) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (empty && !pop_acc) state_nxt = ST_ENDED;
            ST_ENDED:   if (arm) state_nxt = ST_CAPTURE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        capture_en     = (state == ST_CAPTURE);
        rearm          = arm && ((state == ST_IDLE) || (state == ST_ENDED));
        test_has_ended = (state == ST_ENDED);
        state_dbg      = state;
    end

    // A write at full with a concurrent pop is a plain replace; only without
    // a pop does full trigger the drop / overwrite-oldest policy.
    always_comb begin
        pop_acc  = rd_en && !empty;
        wr_req   = capture_en && dct_valid;
        wr_store = wr_req && (!full || pop_acc || (WRAP_MODE != 0));
        wr_wrap  = wr_req && full && !pop_acc && (WRAP_MODE != 0);
        wr_drop  = wr_req && full && !pop_acc && (WRAP_MODE == 0);
        count_nxt = dct_count;
        if (wr_store && !wr_wrap && !pop_acc) begin
            count_nxt = dct_count + CNT_W'(1);
        end else if (pop_acc && !wr_store) begin
            count_nxt = dct_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_store) begin
            mem[wr_ptr] <= dct_buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dct_count <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (rearm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dct_count <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr_store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc || wr_wrap) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            dct_count <= count_nxt;
            full      <= (count_nxt == CNT_W'(DEPTH));
            empty     <= (count_nxt == '0);
            if (wr_wrap || wr_drop) begin
                overflow <= 1'b1;
            end
            rd_valid <= pop_acc;
            if (pop_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_cpu1_oci_dct_capture.sv
// Directed bench for the DCT capture buffer: a stop-mode and a wrap-mode
// instance share stimulus; each has its own expected-read queue and monitor.
module tb_cpu1_oci_dct_capture;

    localparam int DW = 30;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          arm = 1'b0;
    logic          dct_valid = 1'b0;
    logic [DW-1:0] dct_buffer = '0;
    logic          test_ending = 1'b0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic [4:0]    cnt0, cnt1;
    logic          full0, full1, empty0, empty1, ovf0, ovf1, th0, th1;
    logic [1:0]    st0, st1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    cpu1_oci_dct_capture #(.DATA_W(DW), .DEPTH(16), .WRAP_MODE(0), .CNT_W(5)) dut0 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .test_ending(test_ending), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .dct_count(cnt0), .full(full0),
        .empty(empty0), .overflow(ovf0), .test_has_ended(th0), .state_dbg(st0)
    );

    cpu1_oci_dct_capture #(.DATA_W(DW), .DEPTH(16), .WRAP_MODE(1), .CNT_W(5)) dut1 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .test_ending(test_ending), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .dct_count(cnt1), .full(full1),
        .empty(empty1), .overflow(ovf1), .test_has_ended(th1), .state_dbg(st1)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitors: one per instance, popping the expected queue on rd_valid
    always @(negedge clk) begin
        exp_t e;
        if (exp_q0.size() > 0 && exp_q0[0].due < cyc) begin
            e = exp_q0.pop_front();
            chk("rd_missed0", 32'(rd_valid0), 32'd1);
        end
        if (rd_valid0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                chk("rd_unexpected0", 32'(rd_valid0), 32'd0);
            end else begin
                e = exp_q0.pop_front();
                chk("rd_data0", 32'(rd_data0), 32'(e.data));
                chk("rd_latency0", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q1.size() > 0 && exp_q1[0].due < cyc) begin
            e = exp_q1.pop_front();
            chk("rd_missed1", 32'(rd_valid1), 32'd1);
        end
        if (rd_valid1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                chk("rd_unexpected1", 32'(rd_valid1), 32'd0);
            end else begin
                e = exp_q1.pop_front();
                chk("rd_data1", 32'(rd_data1), 32'(e.data));
                chk("rd_latency1", 32'(cyc), 32'(e.due));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_end();
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        dct_valid  = 1'b1;
        dct_buffer = w;
        tick();
        dct_valid  = 1'b0;
    endtask

    task automatic pop_expect(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        exp_t e;
        e.due = cyc + 1;
        e.data = e0;
        exp_q0.push_back(e);
        e.data = e1;
        exp_q1.push_back(e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_both(input string name, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] exp);
        chk({name, "0"}, a0, exp);
        chk({name, "1"}, a1, exp);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        @(negedge clk);
        chk_both("rst_count", 32'(cnt0), 32'(cnt1), 32'd0);
        chk_both("rst_empty", 32'(empty0), 32'(empty1), 32'd1);
        chk_both("rst_full", 32'(full0), 32'(full1), 32'd0);
        chk_both("rst_ovf", 32'(ovf0), 32'(ovf1), 32'd0);
        chk_both("rst_th", 32'(th0), 32'(th1), 32'd0);
        chk_both("rst_rv", 32'(rd_valid0), 32'(rd_valid1), 32'd0);
        chk_both("rst_rdata", 32'(rd_data0), 32'(rd_data1), 32'd0);
        chk_both("rst_state", 32'(st0), 32'(st1), 32'd0);
        reset_n = 1'b1;

        // basic order: five words, drain, ended one cycle after last read
        tick();
        pulse_arm();
        for (int i = 1; i <= 5; i++) write_word(DW'(i));
        pulse_end();
        @(negedge clk);
        chk_both("basic_count", 32'(cnt0), 32'(cnt1), 32'd5);
        chk_both("basic_state", 32'(st0), 32'(st1), 32'd2);
        for (int i = 1; i <= 5; i++) pop_expect(DW'(i), DW'(i));
        @(negedge clk);
        chk_both("basic_count_end", 32'(cnt0), 32'(cnt1), 32'd0);
        chk_both("basic_empty", 32'(empty0), 32'(empty1), 32'd1);
        chk_both("basic_th_early", 32'(th0), 32'(th1), 32'd0);
        tick();
        @(negedge clk);
        chk_both("basic_th", 32'(th0), 32'(th1), 32'd1);

        // overfill with 20 words: stop mode keeps 0x00.., wrap mode keeps 0x04..
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        pulse_arm();
        for (int i = 0; i < 20; i++) write_word(DW'(i));
        @(negedge clk);
        chk_both("ovf_count", 32'(cnt0), 32'(cnt1), 32'd16);
        chk_both("ovf_full", 32'(full0), 32'(full1), 32'd1);
        chk_both("ovf_flag", 32'(ovf0), 32'(ovf1), 32'd1);

        // write and pop together at full: count holds, oldest word comes out
        dct_valid  = 1'b1;
        dct_buffer = 30'h3FFFFFFF;
        pop_expect(30'h00, 30'h04);
        dct_valid  = 1'b0;
        @(negedge clk);
        chk_both("conc_count", 32'(cnt0), 32'(cnt1), 32'd16);
        chk_both("conc_ovf", 32'(ovf0), 32'(ovf1), 32'd1);
        pulse_end();
        for (int i = 1; i <= 15; i++) pop_expect(DW'(i), DW'(i + 4));
        pop_expect(30'h3FFFFFFF, 30'h3FFFFFFF);
        tick();
        @(negedge clk);
        chk_both("drain_count", 32'(cnt0), 32'(cnt1), 32'd0);
        chk_both("drain_th", 32'(th0), 32'(th1), 32'd1);

        // re-arm from ENDED clears overflow and ended flag
        pulse_arm();
        @(negedge clk);
        chk_both("rearm_th", 32'(th0), 32'(th1), 32'd0);
        chk_both("rearm_ovf", 32'(ovf0), 32'(ovf1), 32'd0);
        chk_both("rearm_count", 32'(cnt0), 32'(cnt1), 32'd0);
        write_word(30'h2A);
        pop_expect(30'h2A, 30'h2A);
        tick();

        // pop while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        chk_both("epop_rv", 32'(rd_valid0), 32'(rd_valid1), 32'd0);
        chk_both("epop_count", 32'(cnt0), 32'(cnt1), 32'd0);

        // seven words with an ignored arm mid-capture, then reset in DRAIN
        for (int i = 0; i < 3; i++) write_word(DW'(32'h100 + i));
        arm = 1'b1;
        write_word(30'h103);
        arm = 1'b0;
        for (int i = 4; i < 7; i++) write_word(DW'(32'h100 + i));
        pulse_end();
        @(negedge clk);
        chk_both("pre_rst_count", 32'(cnt0), 32'(cnt1), 32'd7);
        chk_both("pre_rst_state", 32'(st0), 32'(st1), 32'd2);
        reset_n = 1'b0;
        rd_en   = 1'b1;
        tick();
        reset_n = 1'b1;
        rd_en   = 1'b0;
        @(negedge clk);
        chk_both("mid_rst_state", 32'(st0), 32'(st1), 32'd0);
        chk_both("mid_rst_count", 32'(cnt0), 32'(cnt1), 32'd0);
        chk_both("mid_rst_empty", 32'(empty0), 32'(empty1), 32'd1);
        chk_both("mid_rst_th", 32'(th0), 32'(th1), 32'd0);
        chk_both("mid_rst_rv", 32'(rd_valid0), 32'(rd_valid1), 32'd0);
        chk_both("mid_rst_rdata", 32'(rd_data0), 32'(rd_data1), 32'd0);

        // test_ending in IDLE is ignored
        pulse_end();
        @(negedge clk);
        chk_both("idle_end_state", 32'(st0), 32'(st1), 32'd0);

        tick();
        tick();
        @(negedge clk);
        chk_both("leftover_exp", 32'(exp_q0.size()), 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu1_oci_dct_capture.md
CPU1_OCI_DCT_CAPTURE -- requirements
Module: CPU1_oci_dct_capture

Interface
REQ-001 Parameter DATA_W, default 30: width of one debug-capture-trace (DCT) word.
REQ-002 Parameter DEPTH, default 16: buffer entries; power of two, 2..256.
REQ-003 Parameter WRAP_MODE, default 0: 0 = stop-when-full, 1 = overwrite-oldest.
REQ-004 Parameter CNT_W, default 5: occupancy counter width, equal to log2(DEPTH)+1.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 arm  input  1  one-cycle pulse; starts capture.
REQ-008 dct_valid  input  1  qualifies dct_buffer this cycle.
REQ-009 dct_buffer  input  DATA_W  trace word to capture.
REQ-010 test_ending  input  1  one-cycle pulse; ends capture and enters drain.
REQ-011 rd_en  input  1  pop request.
REQ-012 rd_data  output  DATA_W  popped word, registered.
REQ-013 rd_valid  output  1  qualifies rd_data.
REQ-014 dct_count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-015 full / empty  output  1 each  dct_count==DEPTH / dct_count==0.
REQ-016 overflow  output  1  sticky; a word was dropped or overwritten.
REQ-017 test_has_ended  output  1  capture ended and buffer fully drained.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE, DRAIN and ENDED; after reset it SHALL be in IDLE.
- IDLE -> CAPTURE on arm.
- CAPTURE -> DRAIN on test_ending.
- DRAIN -> ENDED when empty is 1 and no pop is in flight.
- ENDED -> CAPTURE on arm.
REQ-019 Writes SHALL be accepted only in CAPTURE with dct_valid=1; in all other states dct_valid SHALL be ignored.
REQ-020 A capture cycle coinciding with test_ending SHALL still write its word; the FSM enters DRAIN on the next cycle.
REQ-021 Pops SHALL be accepted in any state when rd_en=1 and empty=0; a pop while empty SHALL be ignored, with no pointer change and rd_valid=0.
REQ-022 rd_data and rd_valid SHALL appear exactly one cycle after an accepted pop; rd_valid SHALL be a one-cycle pulse per pop.
REQ-023 rd_data SHALL hold its last value when rd_valid=0.
REQ-024 Simultaneous accepted write and pop SHALL leave dct_count unchanged, including at full; the popped word is the oldest entry.
REQ-025 Write when full, no pop, WRAP_MODE=0: the word SHALL be dropped, overflow SHALL be set, and contents and count SHALL be unchanged.
REQ-026 Write when full, no pop, WRAP_MODE=1: the oldest entry SHALL be overwritten, the read pointer SHALL advance by 1, count SHALL stay DEPTH, and overflow SHALL be set.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; dct_count SHALL never exceed DEPTH or go below 0.
REQ-028 full, empty and dct_count SHALL be registered and reflect the state after the current edge, with no combinational path from inputs.
REQ-029 arm in IDLE or ENDED SHALL clear pointers, count and overflow in the same cycle it enters CAPTURE.
REQ-030 arm in CAPTURE or DRAIN SHALL be ignored.
REQ-031 test_ending outside CAPTURE SHALL be ignored.
REQ-032 test_has_ended SHALL be 1 only in ENDED and SHALL fall on the cycle after an accepted re-arm.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL enter the following state.
- FSM to IDLE; pointers, dct_count and overflow to 0.
- empty=1, full=0.
- rd_valid=0, rd_data all-zero, test_has_ended=0.
REQ-034 Reset asserted mid-capture or mid-drain SHALL abandon the buffer contents; any pop issued in the reset cycle SHALL produce no rd_valid.
REQ-035 Buffer storage need not be reset; its contents SHALL never be observable until written.

Verification (DATA_W=30, DEPTH=16)
REQ-036 Basic order: arm, write 0x1..0x5, test_ending, pop 5 times -> rd_data 0x1..0x5, each one cycle after its pop; dct_count 5->0; test_has_ended=1 one cycle after the final pop.
REQ-037 Stop-mode full (WRAP_MODE=0): write 0x00..0x13 (20 words) -> full=1, dct_count=16, overflow=1; pops return 0x00..0x0F.
REQ-038 Wrap mode (WRAP_MODE=1): write 0x00..0x13 -> dct_count=16, overflow=1; pops return 0x04..0x13.
REQ-039 Full concurrency: at full, write 0x3FFFFFFF with simultaneous pop -> dct_count stays 16, rd_data is the oldest word, overflow unchanged.
REQ-040 Empty pop and reset: pop while empty -> rd_valid=0, count 0. Reset asserted with count 7 in DRAIN -> next cycle IDLE, count 0, empty=1, test_has_ended=0.
REQ-041 Re-arm: in ENDED, arm -> test_has_ended=0 next cycle, overflow cleared, write 0x2A captured and popped as 0x2A.
